// File: rtl/hilo_muldiv_pkg.sv
// Shared ALU op codes, divide FSM encoding and sign helpers for the HI/LO unit.
package hilo_muldiv_pkg;

    localparam logic [7:0] OpMult  = 8'b0001_1000;
    localparam logic [7:0] OpMultu = 8'b0001_1001;
    localparam logic [7:0] OpDiv   = 8'b0001_1010;
    localparam logic [7:0] OpDivu  = 8'b0001_1011;
    localparam logic [7:0] OpMthi  = 8'b0001_0001;
    localparam logic [7:0] OpMtlo  = 8'b0001_0011;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } div_state_e;

    function automatic logic [31:0] neg_if(input logic en, input logic [31:0] v);
        return en ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/hilo_muldiv_div_radix2.sv
// Unsigned radix-2 restoring divider: one quotient bit per cycle after start_i.
module div_radix2 #(
    parameter int unsigned DIV_ITERS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [DIV_ITERS-1:0] dividend_i,
    input  logic [DIV_ITERS-1:0] divisor_i,
    output logic                 busy_o,
    output logic                 last_o,
    output logic                 valid_o,
    output logic [DIV_ITERS-1:0] quotient_o,
    output logic [DIV_ITERS-1:0] remainder_o
);
    localparam int unsigned W    = DIV_ITERS;
    localparam int unsigned CntW = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;

    logic [W-1:0]    rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d, valid_q, valid_d;
    logic [W:0]      shifted, diff;

    assign last_o      = busy_q && (cnt_q == CntW'(DIV_ITERS - 1));
    assign busy_o      = busy_q;
    assign valid_o     = valid_q;
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

    always_comb begin
        shifted = {rem_q, quo_q[W-1]};
        diff    = shifted - {1'b0, dvs_q};
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        if (abort_i) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (start_i) begin
            rem_d  = '0;
            quo_d  = dividend_i;
            dvs_d  = divisor_i;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            // Negative trial difference means restore: keep the shifted remainder.
            if (diff[W]) begin
                rem_d = shifted[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b0};
            end else begin
                rem_d = diff[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b1};
            end
            if (last_o) begin
                busy_d  = 1'b0;
                valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// Execute-stage HI/LO unit: single-cycle multiply, iterative divide, MTHI/MTLO.
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int unsigned DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  alucontrolE,
    input  logic        hilowriteE,
    input  logic        flushE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    output logic        stallE,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    div_state_e  state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d, rawa_q, rawa_d;
    logic        qsign_q, qsign_d, rsign_q, rsign_d, div0_q, div0_d;
    logic        hl_we, is_signed, div_start, div_abort;
    logic        div_busy, div_last, div_valid;
    logic [31:0] div_quo, div_rem, abs_a, abs_b;
    logic [63:0] prod;

    assign hl_we     = hilowriteE && !flushE;
    assign is_signed = (alucontrolE == OpDiv) || (alucontrolE == OpMult);
    assign abs_a     = neg_if(is_signed && srcaE[31], srcaE);
    assign abs_b     = neg_if(is_signed && srcbE[31], srcbE);
    // Low 64 bits of the extended product equal the signed or unsigned result.
    assign prod = {{32{is_signed & srcaE[31]}}, srcaE} * {{32{is_signed & srcbE[31]}}, srcbE};

    div_radix2 #(
        .DIV_ITERS(DIV_ITERS)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .abort_i    (div_abort),
        .dividend_i (abs_a),
        .divisor_i  (abs_b),
        .busy_o     (div_busy),
        .last_o     (div_last),
        .valid_o    (div_valid),
        .quotient_o (div_quo),
        .remainder_o(div_rem)
    );

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        rawa_d    = rawa_q;
        qsign_d   = qsign_q;
        rsign_d   = rsign_q;
        div0_d    = div0_q;
        div_start = 1'b0;
        div_abort = 1'b0;
        stallE    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (hl_we) begin
                    case (alucontrolE)
                        OpMult, OpMultu: {hi_d, lo_d} = prod;
                        OpMthi:          hi_d = srcaE;
                        OpMtlo:          lo_d = srcaE;
                        OpDiv, OpDivu: begin
                            div_start = 1'b1;
                            stallE    = 1'b1;
                            state_d   = StBusy;
                            rawa_d    = srcaE;
                            div0_d    = (srcbE == 32'd0);
                            qsign_d   = is_signed && (srcaE[31] ^ srcbE[31]);
                            rsign_d   = is_signed && srcaE[31];
                        end
                        default: ;
                    endcase
                end
            end
            StBusy: begin
                stallE = 1'b1;
                if (flushE) begin
                    div_abort = 1'b1;
                    state_d   = StIdle;
                end else if (div_last) begin
                    state_d = StDone;
                end else if (!div_busy) begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                state_d = StIdle;
                if (!flushE && div_valid) begin
                    lo_d = div0_q ? 32'hFFFF_FFFF : neg_if(qsign_q, div_quo);
                    hi_d = div0_q ? rawa_q : neg_if(rsign_q, div_rem);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            hi_q    <= '0;
            lo_q    <= '0;
            rawa_q  <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            rawa_q  <= rawa_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            div0_q  <= div0_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: multiply, MTHI/MTLO, divide latency, flush and reset abort.
module tb_hilo_muldiv;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  alucontrolE;
    logic        hilowriteE;
    logic        flushE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        stallE;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [7:0] MULT  = 8'b0001_1000;
    localparam logic [7:0] MULTU = 8'b0001_1001;
    localparam logic [7:0] DIV   = 8'b0001_1010;
    localparam logic [7:0] DIVU  = 8'b0001_1011;
    localparam logic [7:0] MTHI  = 8'b0001_0001;
    localparam logic [7:0] MTLO  = 8'b0001_0011;

    hilo_muldiv #(
        .DIV_ITERS(32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alucontrolE(alucontrolE),
        .hilowriteE (hilowriteE),
        .flushE     (flushE),
        .srcaE      (srcaE),
        .srcbE      (srcbE),
        .stallE     (stallE),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alucontrolE = 8'd0;
        hilowriteE  = 1'b0;
        flushE      = 1'b0;
        srcaE       = 32'd0;
        srcbE       = 32'd0;
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        alucontrolE = op;
        hilowriteE  = 1'b1;
        srcaE       = a;
        srcbE       = b;
    endtask

    // Single-cycle op: stall must stay low, result visible after the edge.
    task automatic one_cycle(input string tag, input logic [7:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        issue(op, a, b);
        #1;
        chk({tag, "_stall"}, {31'd0, stallE}, 32'd0);
        tick();
        idle_inputs();
        chk({tag, "_hi"}, hi_o, eh);
        chk({tag, "_lo"}, lo_o, el);
    endtask

    task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ph, input logic [31:0] pl,
                           input logic [31:0] eh, input logic [31:0] el);
        int cycles = 0;
        issue(op, a, b);
        #1;
        while (stallE === 1'b1 && cycles < 100) begin
            cycles++;
            tick();
        end
        chk({tag, "_stall_cycles"}, 32'(cycles), 32'd33);
        chk({tag, "_hi_pre"}, hi_o, ph);
        chk({tag, "_lo_pre"}, lo_o, pl);
        tick();
        idle_inputs();
        chk({tag, "_hi"}, hi_o, eh);
        chk({tag, "_lo"}, lo_o, el);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_hi", hi_o, 32'd0);
        chk("reset_lo", lo_o, 32'd0);
        chk("reset_stall", {31'd0, stallE}, 32'd0);

        one_cycle("mult", MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        one_cycle("multu", MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
        one_cycle("mthi", MTHI, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFE);

        // Flushed op must not write.
        issue(MTLO, 32'hDEAD_BEEF, 32'd0);
        flushE = 1'b1;
        tick();
        idle_inputs();
        chk("flushed_mtlo_lo", lo_o, 32'hFFFF_FFFE);

        run_div("divu", DIVU, 32'd100, 32'd7, 32'h1234_5678, 32'hFFFF_FFFE, 32'd2, 32'd14);
        run_div("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 32'd2, 32'd14,
                32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_div("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                32'd0, 32'h8000_0000);
        run_div("divu_zero", DIVU, 32'h55, 32'd0, 32'd0, 32'h8000_0000,
                32'h55, 32'hFFFF_FFFF);

        // Flush on stall cycle 10.
        one_cycle("pre_hi", MTHI, 32'hAAAA, 32'd0, 32'hAAAA, 32'hFFFF_FFFF);
        one_cycle("pre_lo", MTLO, 32'hBBBB, 32'd0, 32'hAAAA, 32'hBBBB);
        issue(DIV, 32'd1000, 32'd3);
        for (int i = 0; i < 9; i++) tick();
        flushE = 1'b1;
        #1;
        chk("flush_stall_before", {31'd0, stallE}, 32'd1);
        tick();
        idle_inputs();
        #1;
        chk("flush_stall_after", {31'd0, stallE}, 32'd0);
        for (int i = 0; i < 40; i++) tick();
        chk("flush_hi", hi_o, 32'hAAAA);
        chk("flush_lo", lo_o, 32'hBBBB);
        one_cycle("mult_after_flush", MULT, 32'd6, 32'd7, 32'd0, 32'd42);

        // Reset on stall cycle 10.
        one_cycle("pre2_hi", MTHI, 32'hAAAA, 32'd0, 32'hAAAA, 32'd42);
        one_cycle("pre2_lo", MTLO, 32'hBBBB, 32'd0, 32'hAAAA, 32'hBBBB);
        issue(DIV, 32'd1000, 32'd3);
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        #1;
        chk("rst_hi", hi_o, 32'd0);
        chk("rst_lo", lo_o, 32'd0);
        chk("rst_stall", {31'd0, stallE}, 32'd0);
        run_div("divu_after_rst", DIVU, 32'd9, 32'd3, 32'd0, 32'd0, 32'd0, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Execute-stage consumer of the decoded ALU control and HI/LO write-enable from the pipeline controller.
- Executes MULT/MULTU in a single cycle and DIV/DIVU as a 32-iteration radix-2 restoring divider. Owns the architectural HI/LO registers and services MTHI/MTLO.
- Raises a stall to the hazard unit while a divide is in flight.

Parameters:
- DIV_ITERS, 32, divider iteration count; must equal the operand width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- alucontrolE  in  8  decoded ALU op for the instruction in E
- hilowriteE  in  1  instruction in E writes HI/LO
- flushE  in  1  E-stage flush; cancels any pending or in-flight HI/LO update
- srcaE  in  32  rs operand (forwarded)
- srcbE  in  32  rt operand (forwarded)
- stallE  out  1  divide busy; hazard unit freezes F/D/E while high
- hi_o  out  32  architectural HI (registered)
- lo_o  out  32  architectural LO (registered)

Behaviour:
- Reset: hi_o=0, lo_o=0, stallE=0, FSM=IDLE, iteration counter=0. rst has priority over every other input.
- Op encodings (alucontrolE):
  - MULT 8'b00011000, MULTU 8'b00011001
  - DIV 8'b00011010, DIVU 8'b00011011
  - MTHI 8'b00010001, MTLO 8'b00010011
  - All other codes: no HI/LO action.
- No HI/LO update ever happens unless hilowriteE=1 and flushE=0.
- MTHI: HI<=srcaE at the clock edge; LO unchanged. MTLO: LO<=srcaE; HI unchanged.
- MULT/MULTU: 64-bit product (signed or unsigned) written as {HI,LO} at the same edge. Zero stall.
- FSM states: IDLE, BUSY, DONE.
- IDLE to BUSY: on DIV/DIVU with hilowriteE=1 and flushE=0.
  - stallE is high combinationally in that same cycle.
  - At the edge, latch |srcaE| and |srcbE|; absolute value applies to DIV only.
  - Latch the quotient sign (sa^sb) and remainder sign (sa), both for DIV only.
  - Clear the counter.
- BUSY: one restoring shift/subtract step per cycle; stallE=1.
  - After step DIV_ITERS, go to DONE.
  - Counter saturates at DIV_ITERS-1 then transitions.
- DONE (one cycle): stallE=0.
  - At this edge LO<=quotient and HI<=remainder, with sign fixups (negate if the latched sign is set).
  - The pipeline advances on the same edge; FSM returns to IDLE.
- Latency: DIV presented in cycle t gives stallE=1 for t..t+32 (33 cycles) and 0 in t+33. HI/LO are visible from t+34.
- Divide by zero (srcbE=0): LO=32'hFFFFFFFF, HI=srcaE (raw operand), no sign fixup, same 33-cycle stall.
- Signed overflow (0x80000000 / -1): LO=0x80000000, HI=0 (natural result of the algorithm).
- flushE in BUSY or DONE: go to IDLE next edge, no HI/LO write, stallE=0 from the next cycle.
- rst mid-divide: abort to the reset state at the next edge.
- hi_o/lo_o change only at clock edges. MFHI/MFLO in E read the pre-edge value; the same-cycle write is not bypassed (the forwarding unit handles that).
- While stallE=1, alucontrolE, hilowriteE and the operands are held stable by the hazard unit. The divider ignores them after the IDLE to BUSY edge.

Decomposition:
- The shared ALU op package/defines header holds:
  - the 8-bit alucontrol codes listed above
  - FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2)
- One sub-module, div_radix2, containing:
  - the unsigned 32-bit restoring divider datapath
  - start/abort inputs, busy/valid outputs, quotient/remainder outputs
- hilo_muldiv keeps sign handling, the multiplier, the FSM glue and the HI/LO registers.

Test Plan:
- MULT srcaE=0xFFFFFFFD (-3), srcbE=5 -> next cycle HI=0xFFFFFFFF, LO=0xFFFFFFF1; stallE never high.
- MULTU srcaE=0xFFFFFFFF, srcbE=2 -> HI=0x00000001, LO=0xFFFFFFFE. Then MTHI srcaE=0x12345678 -> HI=0x12345678, LO unchanged.
- DIVU 100/7 -> stallE high exactly 33 cycles, then LO=0x0000000E, HI=0x00000002.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x55 / 0 -> after 33 stall cycles LO=0xFFFFFFFF, HI=0x00000055.
- With HI/LO preloaded to 0xAAAA/0xBBBB, start DIV, then do one of:
  - assert flushE on stall cycle 10 -> stallE low next cycle, HI/LO unchanged, a new MULT immediately after works.
  - assert rst on stall cycle 10 -> HI=LO=0, stallE=0.
